// File: rtl/shift_pkg.sv
// Shared definitions for the tapped shift line and its bench.
//   shift_mode_e : operating mode applied while En=1
//     SHIFT  - SI enters stage 0, every stage moves one step deeper
//     ROTATE - the word at the tap re-enters stage 0, SI is ignored
//     HOLD   - nothing moves
//     FLUSH  - every stage and valid bit is cleared in one cycle
package shift_pkg;

  typedef enum logic [1:0] {
    SHIFT  = 2'd0,
    ROTATE = 2'd1,
    HOLD   = 2'd2,
    FLUSH  = 2'd3
  } shift_mode_e;

endpackage : shift_pkg

// File: rtl/shift_stage.sv
// One stage of the tapped shift line: a W-bit data register plus its valid bit.
// Ports:
//   clk_i    clock, all updates on posedge
//   clr_n_i  synchronous active-low clear, dominates everything else
//   en_i     stage may update this cycle; 0 = hold
//   load_i   with en_i: capture d_i / v_i
//   clear_i  with en_i: zero data and valid (wins over load_i)
//   d_i      incoming data word
//   v_i      incoming valid bit
//   d_o      stored data word
//   v_o      stored valid bit
module shift_stage #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         clr_n_i,
  input  logic         en_i,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] d_i,
  input  logic         v_i,
  output logic [W-1:0] d_o,
  output logic         v_o
);

  logic [W-1:0] data_q, data_d;
  logic         vld_q, vld_d;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (en_i) begin
      if (clear_i) begin
        data_d = '0;
        vld_d  = 1'b0;
      end else if (load_i) begin
        data_d = d_i;
        vld_d  = v_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign d_o = data_q;
  assign v_o = vld_q;

endmodule : shift_stage

// File: rtl/tapped_shift_line.sv
// Programmable-latency delay line: D stages of W-bit data, each with a valid
// bit, and a runtime-selectable output tap.
// Ports:
//   Clk      clock, all state changes on posedge
//   Clr      synchronous active-low reset, dominates En and Mode
//   En       advance enable; 0 = every stage holds
//   Mode     shift_mode_e: SHIFT / ROTATE / HOLD / FLUSH
//   Depth    requested tap depth; 0 acts as 1, values above D act as D
//   SI       serial data in
//   SIValid  SI carries a valid word
//   SO       data at the selected tap (stage Eff-1)
//   SOValid  valid bit at the selected tap
//   Count    number of valid stages among 0..Eff-1
// Valid semantics: SIValid qualifies SI on any enabled SHIFT cycle and travels
// with the word; there is no ready/backpressure, the line always accepts. A
// word with SIValid=0 is a bubble whose data content is don't-care and can
// never raise SOValid. Outputs are combinational from the stages, so latency
// from SI to SO is exactly Eff enabled SHIFT cycles.
module tapped_shift_line
  import shift_pkg::*;
#(
  parameter  int W  = 4,
  parameter  int D  = 4,
  localparam int DW = $clog2(D + 1)
) (
  input  logic          Clk,
  input  logic          Clr,
  input  logic          En,
  input  shift_mode_e   Mode,
  input  logic [DW-1:0] Depth,
  input  logic [W-1:0]  SI,
  input  logic          SIValid,
  output logic [W-1:0]  SO,
  output logic          SOValid,
  output logic [DW-1:0] Count
);

  localparam logic [DW-1:0] D_MAX = DW'(D);

  logic [W-1:0]  stage_data [D];
  logic          stage_vld  [D];

  logic [DW-1:0] eff;
  logic [DW-1:0] tap_idx;
  logic [W-1:0]  tap_data;
  logic          tap_vld;
  logic [W-1:0]  head_d;
  logic          head_v;
  logic          load;
  logic          clear;
  logic [DW-1:0] vld_cnt;

  // Effective depth: clamp requested depth into 1..D.
  always_comb begin
    eff = Depth;
    if (Depth == '0) begin
      eff = DW'(1);
    end else if (Depth > D_MAX) begin
      eff = D_MAX;
    end
  end

  assign tap_idx = eff - DW'(1);

  // Output tap mux, written as a compare loop so the index width never has to
  // match the array bound exactly.
  always_comb begin
    tap_data = '0;
    tap_vld  = 1'b0;
    for (int i = 0; i < D; i++) begin
      if (DW'(i) == tap_idx) begin
        tap_data = stage_data[i];
        tap_vld  = stage_vld[i];
      end
    end
  end

  // Valid stages inside the active window only; deeper stages still shift
  // but are not counted.
  always_comb begin
    vld_cnt = '0;
    for (int i = 0; i < D; i++) begin
      if ((DW'(i) < eff) && stage_vld[i]) begin
        vld_cnt = vld_cnt + DW'(1);
      end
    end
  end

  // Stage 0 input: ROTATE feeds the tap back (with Eff=1 that is stage 0
  // reloading itself), SHIFT takes the serial input.
  always_comb begin
    head_d = SI;
    head_v = SIValid;
    if (Mode == ROTATE) begin
      head_d = tap_data;
      head_v = tap_vld;
    end
  end

  assign load  = (Mode == SHIFT) || (Mode == ROTATE);
  assign clear = (Mode == FLUSH);

  for (genvar g = 0; g < D; g++) begin : g_stage
    logic [W-1:0] d_in;
    logic         v_in;

    if (g == 0) begin : g_head
      assign d_in = head_d;
      assign v_in = head_v;
    end else begin : g_body
      assign d_in = stage_data[g-1];
      assign v_in = stage_vld[g-1];
    end

    shift_stage #(
      .W(W)
    ) u_stage (
      .clk_i   (Clk),
      .clr_n_i (Clr),
      .en_i    (En),
      .load_i  (load),
      .clear_i (clear),
      .d_i     (d_in),
      .v_i     (v_in),
      .d_o     (stage_data[g]),
      .v_o     (stage_vld[g])
    );
  end

  assign SO      = tap_data;
  assign SOValid = tap_vld;
  assign Count   = vld_cnt;

endmodule : tapped_shift_line

// File: tb/tb_tapped_shift_line.sv
module tb_tapped_shift_line;
  import shift_pkg::*;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int DW = $clog2(D + 1);

  logic          Clk;
  logic          Clr;
  logic          En;
  shift_mode_e   Mode;
  logic [DW-1:0] Depth;
  logic [W-1:0]  SI;
  logic          SIValid;
  logic [W-1:0]  SO;
  logic          SOValid;
  logic [DW-1:0] Count;

  tapped_shift_line #(
    .W(W),
    .D(D)
  ) dut (
    .Clk     (Clk),
    .Clr     (Clr),
    .En      (En),
    .Mode    (Mode),
    .Depth   (Depth),
    .SI      (SI),
    .SIValid (SIValid),
    .SO      (SO),
    .SOValid (SOValid),
    .Count   (Count)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_v_q[$];

  typedef struct {
    logic          clr;
    logic          en;
    shift_mode_e   mode;
    logic [DW-1:0] depth;
    logic [W-1:0]  si;
    logic          siv;
    logic [W-1:0]  so;
    logic          sov;
    logic [DW-1:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic clr, input logic en, input shift_mode_e mode,
                              input int depth, input int si, input logic siv,
                              input int so, input logic sov, input int cnt);
    vec_t v;
    v.clr   = clr;
    v.en    = en;
    v.mode  = mode;
    v.depth = DW'(depth);
    v.si    = W'(si);
    v.siv   = siv;
    v.so    = W'(so);
    v.sov   = sov;
    v.cnt   = DW'(cnt);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic clr, input logic en, input shift_mode_e mode,
                       input logic [DW-1:0] depth, input logic [W-1:0] si, input logic siv);
    Clr     = clr;
    En      = en;
    Mode    = mode;
    Depth   = depth;
    SI      = si;
    SIValid = siv;
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    drive(v.clr, v.en, v.mode, v.depth, v.si, v.siv);
    tick();
    check($sformatf("vec%0d_so", idx), 32'(SO), 32'(v.so));
    check($sformatf("vec%0d_sov", idx), 32'(SOValid), 32'(v.sov));
    check($sformatf("vec%0d_cnt", idx), 32'(Count), 32'(v.cnt));
  endtask

  // Flush, then push four valid words followed by Eff bubbles. exp_q holds the
  // words in stages 0..Eff-2 after each pop; the popped entry is the tap.
  task automatic run_latency(input int depth, input int eff, input logic [W-1:0] w0,
                             input logic [W-1:0] w1, input logic [W-1:0] w2, input logic [W-1:0] w3);
    logic [W-1:0] words [4];
    logic [W-1:0] e_d;
    logic         e_v;
    int           e_cnt;
    words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
    drive(1'b1, 1'b1, FLUSH, DW'(depth), '0, 1'b0);
    tick();
    exp_q.delete();
    exp_v_q.delete();
    for (int k = 0; k < eff - 1; k++) begin
      exp_q.push_back('0);
      exp_v_q.push_back(1'b0);
    end
    for (int k = 0; k < 4 + eff; k++) begin
      if (k < 4) begin
        drive(1'b1, 1'b1, SHIFT, DW'(depth), words[k], 1'b1);
        exp_q.push_back(words[k]);
        exp_v_q.push_back(1'b1);
      end else begin
        drive(1'b1, 1'b1, SHIFT, DW'(depth), '0, 1'b0);
        exp_q.push_back('0);
        exp_v_q.push_back(1'b0);
      end
      tick();
      e_d = exp_q.pop_front();
      e_v = exp_v_q.pop_front();
      e_cnt = int'(e_v);
      foreach (exp_v_q[j]) e_cnt += int'(exp_v_q[j]);
      if (e_v) check($sformatf("lat_d%0d_c%0d_so", depth, k), 32'(SO), 32'(e_d));
      check($sformatf("lat_d%0d_c%0d_sov", depth, k), 32'(SOValid), 32'(e_v));
      check($sformatf("lat_d%0d_c%0d_cnt", depth, k), 32'(Count), 32'(e_cnt));
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    drive(1'b0, 1'b1, SHIFT, DW'(4), 4'h5, 1'b1);

    // Reset: Clr low two cycles (with junk input), then idle with En=0.
    vecs.push_back(mk(0, 1, SHIFT, 4, 'h5, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, SHIFT, 4, 'h5, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, SHIFT, 4, 'h7, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, SHIFT, 4, 'h7, 1, 0, 0, 0));
    foreach (vecs[i]) apply_vec(i, vecs[i]);
    vecs.delete();

    // Latency per depth; Depth=0 behaves as 1.
    run_latency(2, 2, 4'hF, 4'hE, 4'h8, 4'h1);
    run_latency(4, 4, 4'hF, 4'hE, 4'h8, 4'h1);
    run_latency(0, 1, 4'hF, 4'hE, 4'h8, 4'h1);

    // Rotate at Depth=3: stages become [3,2,1,x], then tap sequence 2,3,1.
    vecs.push_back(mk(1, 1, FLUSH,  3, 'h0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, SHIFT,  3, 'h1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, SHIFT,  3, 'h2, 1, 0, 0, 2));
    vecs.push_back(mk(1, 1, SHIFT,  3, 'h3, 1, 1, 1, 3));
    vecs.push_back(mk(1, 1, ROTATE, 3, 'hF, 1, 2, 1, 3));
    vecs.push_back(mk(1, 1, ROTATE, 3, 'hF, 1, 3, 1, 3));
    vecs.push_back(mk(1, 1, ROTATE, 3, 'hF, 1, 1, 1, 3));
    // Fill/hold/flush at Depth=4; En=0 also holds regardless of Mode.
    vecs.push_back(mk(1, 1, FLUSH,  4, 'h0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, SHIFT,  4, 'h9, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, SHIFT,  4, 'hA, 1, 0, 0, 2));
    vecs.push_back(mk(1, 1, SHIFT,  4, 'hB, 1, 0, 0, 3));
    vecs.push_back(mk(1, 1, SHIFT,  4, 'hC, 1, 9, 1, 4));
    vecs.push_back(mk(1, 1, HOLD,   4, 'h5, 1, 9, 1, 4));
    vecs.push_back(mk(1, 1, HOLD,   4, 'h5, 1, 9, 1, 4));
    vecs.push_back(mk(1, 1, HOLD,   4, 'h5, 1, 9, 1, 4));
    vecs.push_back(mk(1, 0, FLUSH,  4, 'h5, 1, 9, 1, 4));
    vecs.push_back(mk(1, 1, FLUSH,  4, 'h5, 1, 0, 0, 0));
    foreach (vecs[i]) apply_vec(100 + i, vecs[i]);
    vecs.delete();

    // Clr priority: fill four stages, then Clr=0 alongside a SHIFT of A.
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b1, SHIFT, DW'(4), W'(k), 1'b1);
      tick();
    end
    check("clr_pre_so", 32'(SO), 32'h1);
    drive(1'b0, 1'b1, SHIFT, DW'(1), 4'hA, 1'b1);
    tick();
    drive(1'b1, 1'b0, SHIFT, DW'(1), 4'hA, 1'b1);
    for (int d = 1; d <= 4; d++) begin
      Depth = DW'(d);
      #1;
      check($sformatf("clr_d%0d_so", d), 32'(SO), 32'h0);
      check($sformatf("clr_d%0d_sov", d), 32'(SOValid), 32'h0);
      check($sformatf("clr_d%0d_cnt", d), 32'(Count), 32'h0);
    end

    // Live depth change: stages [4,3,2,1], then move the tap without a clock.
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b1, SHIFT, DW'(4), W'(k), 1'b1);
      tick();
    end
    check("live_d4_so", 32'(SO), 32'h1);
    Depth = DW'(2); #1;
    check("live_d2_so", 32'(SO), 32'h3);
    check("live_d2_cnt", 32'(Count), 32'h2);
    Depth = DW'(3); #1;
    check("live_d3_so", 32'(SO), 32'h2);
    Depth = DW'(7); #1;
    check("live_d7_so", 32'(SO), 32'h1);
    check("live_d7_cnt", 32'(Count), 32'h4);
    Depth = DW'(0); #1;
    check("live_d0_so", 32'(SO), 32'h4);
    check("live_d0_cnt", 32'(Count), 32'h1);

    // Bubbles with X data at Depth=2: Count drops below Eff, SOValid stays low.
    drive(1'b1, 1'b1, SHIFT, DW'(2), 'x, 1'b0);
    tick();
    check("bub1_so", 32'(SO), 32'h4);
    check("bub1_sov", 32'(SOValid), 32'h1);
    check("bub1_cnt", 32'(Count), 32'h1);
    tick();
    check("bub2_sov", 32'(SOValid), 32'h0);
    check("bub2_cnt", 32'(Count), 32'h0);
    drive(1'b1, 1'b0, SHIFT, DW'(4), 4'h0, 1'b0);
    #1;
    check("bub_d4_so", 32'(SO), 32'h3);
    check("bub_d4_sov", 32'(SOValid), 32'h1);
    check("bub_d4_cnt", 32'(Count), 32'h2);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_tapped_shift_line
